// File: rtl/mem_init_pkg.sv
// mem_init_pkg: shared loader state encoding and word geometry for mem_init_loader.
package mem_init_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/mem_init_loader.sv
// mem_init_loader: packs a little-endian byte stream into words and writes them
// through the SRAM init port, holding the normal port off for the whole load.
module mem_init_loader
    import mem_init_pkg::*;
#(
    parameter int DATA_WIDTH = 8 * BYTES_PER_WORD,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  init_en,
    output logic                  init_we,
    output logic [ADDR_WIDTH-1:0] init_addr,
    output logic [DATA_WIDTH-1:0] init_data,
    output logic                  busy,
    output logic                  done
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [BW-1:0]         byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_word;

    // word_idx is one bit narrower than the count, so compare with headroom
    assign last_word = ({1'b0, word_idx_q} + (ADDR_WIDTH + 1)'(1)) == count_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        addr_d     = addr_q;
        data_d     = data_q;
        case (state_q)
            IDLE: if (start) begin
                count_d    = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
                word_idx_d = '0;
                byte_idx_d = '0;
                state_d    = (num_words == '0) ? DONE : COLLECT;
            end
            COLLECT: if (s_valid) begin
                word_d[8*byte_idx_q +: 8] = s_data;
                if (byte_idx_q == BW'(BPW - 1)) begin
                    addr_d  = word_idx_q;
                    data_d  = word_d;
                    state_d = WRITE;
                end else begin
                    byte_idx_d = byte_idx_q + BW'(1);
                end
            end
            WRITE: if (last_word) begin
                state_d = DONE;
            end else begin
                word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                byte_idx_d = '0;
                state_d    = COLLECT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign s_ready   = state_q == COLLECT;
    assign init_en   = (state_q == COLLECT) || (state_q == WRITE);
    assign init_we   = state_q == WRITE;
    assign init_addr = addr_q;
    assign init_data = data_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_mem_init_loader.sv
// tb_mem_init_loader: scoreboard bench; stimulus queues expected writes/done,
// a negedge monitor pops and compares whenever init_we or done is seen.
module tb_mem_init_loader;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [5:0]  num_words = 0;
    logic        s_valid = 0;
    logic [7:0]  s_data = 0;
    logic        s_ready, init_en, init_we, busy, done;
    logic [4:0]  init_addr;
    logic [31:0] init_data;

    mem_init_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .init_en(init_en), .init_we(init_we), .init_addr(init_addr),
        .init_data(init_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        bit          after_we;
        int          addr;
        logic [31:0] data;
    } ev_t;

    ev_t         sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_we_cyc = -10;
    logic [31:0] exp_mem [32];

    // behavioural SRAM on the init port with a one-cycle registered read
    logic [31:0] mem [32];
    logic [4:0]  rd_addr = 0;
    logic [31:0] data_out;
    always @(posedge clk) begin
        if (init_we) mem[init_addr] <= init_data;
        data_out <= mem[rd_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n && (init_we || done)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event we=%0d done=%0d addr=%0h", init_we, done, init_addr);
            end else begin
                e = sb.pop_front();
                chk("event_kind", {63'd0, done}, {63'd0, e.is_done});
                if (!e.is_done) begin
                    chk("write_addr", {59'd0, init_addr}, 64'(e.addr));
                    chk("write_data", {32'd0, init_data}, {32'd0, e.data});
                    chk("ready_in_write", {63'd0, s_ready}, 64'd0);
                end else begin
                    chk("init_en_in_done", {63'd0, init_en}, 64'd0);
                    if (e.after_we) chk("done_gap", 64'(cyc - last_we_cyc), 64'd1);
                end
            end
            if (init_we) last_we_cyc = cyc;
        end
    end

    function automatic logic [7:0] bval(input int seed, input int i);
        return 8'(seed + i * 37);
    endfunction

    task automatic idle(input int n);
        s_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        logic r;
        int   n = 0;
        s_valid = 1;
        s_data  = b;
        do begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 100);
        if (!r) chk("send_timeout", 64'd0, 64'd1);
        s_valid = 0;
    endtask

    task automatic do_start(input logic [5:0] n);
        start     = 1;
        num_words = n;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input int a, input logic [31:0] d);
        ev_t e;
        e.is_done = 0; e.after_we = 0; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_done(input bit aw);
        ev_t e;
        e.is_done = 1; e.after_we = aw; e.addr = 0; e.data = 0;
        sb.push_back(e);
    endtask

    task automatic load(input int req, input int act, input int seed, input int gapmax);
        for (int w = 0; w < act; w++) begin
            logic [31:0] d;
            for (int k = 0; k < 4; k++) d[8*k +: 8] = bval(seed, 4*w + k);
            push_write(w, d);
            exp_mem[w] = d;
        end
        push_done(1);
        do_start(6'(req));
        for (int i = 0; i < 4*act; i++) begin
            if (gapmax > 0) idle($urandom_range(0, gapmax));
            send(bval(seed, i));
        end
        drain();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_outs"}, {59'd0, s_ready, init_en, init_we, busy, done}, 64'd0);
        chk({nm, "_addr"}, {59'd0, init_addr}, 64'd0);
        chk({nm, "_data"}, {32'd0, init_data}, 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;
        @(posedge clk);
        #1;

        // two words, back-to-back bytes 11..88
        push_write(0, 32'h44332211);
        push_write(1, 32'h88776655);
        push_done(1);
        do_start(6'd2);
        for (int i = 0; i < 8; i++) send(8'(8'h11 * (i + 1)));
        drain();

        // zero-length load
        push_done(0);
        do_start(6'd0);
        @(negedge clk);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_en", {63'd0, init_en}, 64'd0);
        drain();

        // full 32-word load with random gaps, then read back through the SRAM
        load(32, 32, 8'h5a, 2);
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            @(posedge clk);
            #1;
            chk("sram_read", {32'd0, data_out}, {32'd0, exp_mem[a]});
        end

        // oversized count saturates to 32
        load(40, 32, 8'h13, 0);

        // start while busy is ignored
        push_write(0, 32'h04030201);
        push_write(1, 32'h08070605);
        push_done(1);
        do_start(6'd2);
        for (int i = 0; i < 4; i++) send(8'(i + 1));
        do_start(6'd5);
        for (int i = 4; i < 8; i++) send(8'(i + 1));
        drain();
        chk("ignored_start_idle", {63'd0, busy}, 64'd0);

        // reset after 6 bytes of a 3-word load
        push_write(0, 32'hd4c3b2a1);
        do_start(6'd3);
        send(8'ha1); send(8'hb2); send(8'hc3); send(8'hd4); send(8'he5); send(8'hf6);
        rst_n = 0;
        @(posedge clk);
        #1;
        chk_zero("midreset");
        chk("midreset_queue", 64'(sb.size()), 64'd0);
        rst_n = 1;
        @(posedge clk);
        #1;
        load(1, 1, 8'h77, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
